// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
//  Module      : cache_control
//  Description : Cache controller FSM (IDLE / WRITEBACK / ALLOCATE) with
//                zero-wait hits, dirty-victim writeback and line allocate.
//                Optional saturating performance counters are built only
//                when the macro CACHE_CTRL_PERF_CNT_EN is defined; otherwise
//                hit_count / miss_count / wb_count are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp,
   input  logic                 hit,
   input  logic                 dirty,
   output logic                 dp_write_enable,
   output logic                 dp_control_load,
   output logic                 pmem_addr_sel,
   output logic                 pmem_read,
   output logic                 pmem_write,
   input  logic                 pmem_resp,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WRITEBACK = 2'd1;
   localparam logic [1:0] ST_ALLOCATE  = 2'd2;

   logic [1:0] state;
   logic [1:0] state_next;
   logic       req;

   // A simultaneous read and write is handled as a write: dp_write_enable
   // follows mem_write alone, and both simply raise the request.
   assign req = mem_read | mem_write;

   // State register; reset abandons any outstanding memory transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (req && !hit) begin
               state_next = dirty ? ST_WRITEBACK : ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: begin
            // If the CPU withdrew its request, finish the writeback and
            // go home instead of fetching a line nobody is waiting for.
            if (pmem_resp) begin
               state_next = req ? ST_ALLOCATE : ST_IDLE;
            end
         end
         ST_ALLOCATE: begin
            if (pmem_resp) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output decode; everything is forced low while reset is asserted.
   always_comb begin
      mem_resp        = 1'b0;
      dp_write_enable = 1'b0;
      dp_control_load = 1'b0;
      pmem_addr_sel   = 1'b0;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (req && hit) begin
                  mem_resp        = 1'b1;
                  dp_write_enable = mem_write;
               end
            end
            ST_WRITEBACK: begin
               pmem_write    = 1'b1;
               pmem_addr_sel = 1'b1;
            end
            ST_ALLOCATE: begin
               pmem_read       = 1'b1;
               dp_control_load = pmem_resp;
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_CTRL_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic missed;
   logic hit_evt;
   logic miss_evt;
   logic wb_evt;

   // The hit that completes a previously missed request is not a new hit.
   assign hit_evt  = (state == ST_IDLE) && req && hit && !missed;
   assign miss_evt = (state == ST_IDLE) && req && !hit;
   assign wb_evt   = (state == ST_WRITEBACK) && pmem_resp;

   // Remember that the current request already missed; any other IDLE
   // cycle (service or no request) closes the request.
   always_ff @(posedge clk) begin
      if (rst) begin
         missed <= 1'b0;
      end else if (miss_evt) begin
         missed <= 1'b1;
      end else if (state == ST_IDLE) begin
         missed <= 1'b0;
      end
   end

   // Saturating hit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count <= '0;
      end else if (hit_evt && (hit_count != CNT_MAX)) begin
         hit_count <= hit_count + CNT_ONE;
      end
   end

   // Saturating miss counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         miss_count <= '0;
      end else if (miss_evt && (miss_count != CNT_MAX)) begin
         miss_count <= miss_count + CNT_ONE;
      end
   end

   // Saturating writeback counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_count <= '0;
      end else if (wb_evt && (wb_count != CNT_MAX)) begin
         wb_count <= wb_count + CNT_ONE;
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
   assign wb_count   = '0;
`endif

endmodule
`default_nettype wire
